axi4_lite_slave_arb: RTL
========================

// Module: axi4_lite_slave_arb
// PURPOSE
//  Unified AXI4-Lite slave bridging read and write channels onto ONE shared memory port with req/ack wait states.
//  Buffers AW, W and AR independently, arbitrates round-robin, decodes the address window, and passes byte strobes.
//  Bounds memory stalls with a timeout. Sits between the interconnect and the external memory/peripheral model.
// PARAMETERS
//  AXI_ADDR_WIDTH  64        address width
//  AXI_DATA_WIDTH  32        data width; multiple of 8
//  BASE_ADDR       0         first byte address of the decoded window
//  ADDR_RANGE      'h10000   window size in bytes; valid iff BASE_ADDR <= addr < BASE_ADDR+ADDR_RANGE
//  TIMEOUT_CYCLES  256       max cycles mem_req_o waits for an ack; 0 = never time out
// PORTS
//  clk_i          in   1      clock, rising edge
//  arst_ni        in   1      asynchronous active-low reset
//  AR_VALID/AR_READY  in/out  1  read address handshake; AR_ADDR in ADDR_W; AR_PROT in 3 (ignored)
//  R_VALID/R_READY    out/in  1  read data handshake; R_DATA out DATA_W; R_RESP out 2
//  AW_VALID/AW_READY  in/out  1  write address handshake; AW_ADDR in ADDR_W; AW_PROT in 3 (ignored)
//  W_VALID/W_READY    in/out  1  write data handshake; W_DATA in DATA_W; W_STRB in DATA_W/8
//  B_VALID/B_READY    out/in  1  write response handshake; B_RESP out 2
//  mem_req_o      out  1      memory access request; held until ack or timeout
//  mem_we_o       out  1      1 = write, 0 = read
//  mem_addr_o     out  ADDR_W byte address, low log2(DATA_W/8) bits forced 0
//  mem_wdata_o    out  DATA_W write data
//  mem_wstrb_o    out  DATA_W/8 byte enables; all-zero on reads
//  mem_rdata_i    in   DATA_W read data, valid with mem_ack_i
//  mem_ack_i      in   1      access complete; sampled only while mem_req_o=1
//  mem_err_i      in   1      access failed; sampled with mem_ack_i
// BEHAVIOUR
//  Reset (arst_ni=0, async):
//   - All buffers empty; FSM=IDLE; rr flag = "last=write" (read wins the first tie).
//   - All READY/VALID outputs, mem_req_o, R_DATA, R_RESP and B_RESP are 0.
//   - READYs are registered: they rise on the first edge after release.
//  Buffers: one-entry each for AR, AW, W; AR_READY/AW_READY/W_READY = respective buffer empty.
//   - AW and W are accepted in any order or cycle; a write is pending only when both AW and W are full.
//  FSM IDLE -> MEM_RD | MEM_WR | RESP_R | RESP_W:
//   - Read pending only -> read; write pending only -> write.
//   - Both pending -> opposite of the last grant; rr flag updates on grant.
//   - Address outside the window -> skip memory, go straight to RESP_x with DECERR (2'b11), R_DATA=0.
//   - Misaligned address (low bits != 0) -> skip memory, go straight to RESP_x with SLVERR (2'b10).
//  MEM_RD/MEM_WR:
//   - mem_req_o=1, other mem outputs stable; timeout counter counts up from 0.
//   - mem_ack_i=1 -> capture mem_rdata_i; resp = mem_err_i ? SLVERR : OKAY (2'b00); go to RESP_x.
//   - Counter reaches TIMEOUT_CYCLES without ack -> drop mem_req_o, SLVERR, R_DATA=0, go to RESP_x.
//  RESP_R/RESP_W:
//   - R_VALID/B_VALID held with stable data/resp until R_READY/B_READY.
//   - On handshake, clear the AR buffer (read) or both AW and W buffers (write); return to IDLE.
//   - The READY of a cleared buffer rises the next cycle.
//  Concurrency: new AW/W may buffer while a read is in flight, and vice versa; only one memory access at a time.
//  Latency: AR handshake at edge N -> mem_req_o from N+1 -> zero-wait ack at N+1 -> R_VALID from N+2.
//   Write: from the later of the AW/W handshakes, same timing.
//  Reset mid-access: request dropped and buffers flushed; no R/B response is ever issued for it.
// TESTING
//  T1 AR 0x10, mem ack same cycle, rdata 0xDEADBEEF -> R_VALID 2 edges after AR, R_DATA=0xDEADBEEF, R_RESP=00.
//  T2 W (0xA5A5A5A5, strb 0b0101) 3 cycles before AW 0x20 -> one mem write, wstrb=0101, B_RESP=00.
//  T3 AR and AW+W pending in the same IDLE cycle, twice -> order R,W,R,W; mem_req_o never overlaps.
//  T4 AR 0x10000 (outside window) -> no mem_req_o, R_RESP=11, R_DATA=0; write 0x22 -> B_RESP=10, no mem_req_o.
//  T5 TIMEOUT_CYCLES=8, mem_ack_i tied 0 -> mem_req_o drops after 8 cycles, R_RESP=10; next AR still served.
//  T6 arst_ni pulsed low while in MEM_WR -> no B_VALID; all READYs high 1 cycle after release; new write OK.

Source files
------------

// File: rtl/axi4_lite_slave_arb.sv
// AXI4-Lite slave that funnels buffered AR and AW/W requests, round-robin, onto one
// req/ack memory port, with window/alignment decode and a bounded wait for the ack.
module axi4_lite_slave_arb #(
  parameter int                        AXI_ADDR_WIDTH = 64,
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_RANGE     = 'h10000,
  parameter int                        TIMEOUT_CYCLES = 256
) (
  input  logic                        clk_i,
  input  logic                        arst_ni,
  input  logic                        AR_VALID,
  output logic                        AR_READY,
  input  logic [AXI_ADDR_WIDTH-1:0]   AR_ADDR,
  input  logic [2:0]                  AR_PROT,
  output logic                        R_VALID,
  input  logic                        R_READY,
  output logic [AXI_DATA_WIDTH-1:0]   R_DATA,
  output logic [1:0]                  R_RESP,
  input  logic                        AW_VALID,
  output logic                        AW_READY,
  input  logic [AXI_ADDR_WIDTH-1:0]   AW_ADDR,
  input  logic [2:0]                  AW_PROT,
  input  logic                        W_VALID,
  output logic                        W_READY,
  input  logic [AXI_DATA_WIDTH-1:0]   W_DATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] W_STRB,
  output logic                        B_VALID,
  input  logic                        B_READY,
  output logic [1:0]                  B_RESP,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [AXI_ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [AXI_DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0] mem_wstrb_o,
  input  logic [AXI_DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                        mem_ack_i,
  input  logic                        mem_err_i
);
  localparam int                        SW         = AXI_DATA_WIDTH/8;
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = AXI_ADDR_WIDTH'(SW-1);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_MEM_RD, S_MEM_WR, S_RESP_R, S_RESP_W} state_t;

  state_t                    r_state;
  logic                      r_last_wr;
  logic [31:0]               r_tcnt;
  logic                      r_ar_full, r_aw_full, r_w_full;
  logic                      r_ar_rdy, r_aw_rdy, r_w_rdy;
  logic [AXI_ADDR_WIDTH-1:0] r_ar_addr, r_aw_addr;
  logic [AXI_DATA_WIDTH-1:0] r_w_data;
  logic [SW-1:0]             r_w_strb;
  logic                      r_rvalid, r_bvalid;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]                r_rresp, r_bresp;
  logic                      r_mem_req, r_mem_we;
  logic [AXI_ADDR_WIDTH-1:0] r_mem_addr;
  logic [AXI_DATA_WIDTH-1:0] r_mem_wdata;
  logic [SW-1:0]             r_mem_wstrb;

  logic w_ar_hs, w_aw_hs, w_w_hs, w_rd_clr, w_wr_clr;
  logic w_ar_nxt, w_aw_nxt, w_w_nxt;
  logic w_rd_pend, w_wr_pend, w_pick_rd, w_oob, w_mis, w_tmo;
  logic [AXI_ADDR_WIDTH-1:0] w_sel_addr;
  logic [1:0]                w_dec_resp, w_mem_resp;
  logic [AXI_DATA_WIDTH-1:0] w_mem_data;
  logic                      w_unused_prot;

  assign w_unused_prot = ^{AR_PROT, AW_PROT};

  assign w_ar_hs  = AR_VALID & r_ar_rdy;
  assign w_aw_hs  = AW_VALID & r_aw_rdy;
  assign w_w_hs   = W_VALID  & r_w_rdy;
  assign w_rd_clr = (r_state == S_RESP_R) & R_READY;
  assign w_wr_clr = (r_state == S_RESP_W) & B_READY;
  assign w_ar_nxt = w_ar_hs | (r_ar_full & ~w_rd_clr);
  assign w_aw_nxt = w_aw_hs | (r_aw_full & ~w_wr_clr);
  assign w_w_nxt  = w_w_hs  | (r_w_full  & ~w_wr_clr);

  // READY mirrors next-cycle emptiness, so it stays low for the first cycle out of reset.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_ar_full <= 1'b0; r_aw_full <= 1'b0; r_w_full <= 1'b0;
      r_ar_rdy  <= 1'b0; r_aw_rdy  <= 1'b0; r_w_rdy  <= 1'b0;
      r_ar_addr <= '0;   r_aw_addr <= '0;
      r_w_data  <= '0;   r_w_strb  <= '0;
    end else begin
      r_ar_full <= w_ar_nxt;  r_ar_rdy <= ~w_ar_nxt;
      r_aw_full <= w_aw_nxt;  r_aw_rdy <= ~w_aw_nxt;
      r_w_full  <= w_w_nxt;   r_w_rdy  <= ~w_w_nxt;
      if (w_ar_hs) r_ar_addr <= AR_ADDR;
      if (w_aw_hs) r_aw_addr <= AW_ADDR;
      if (w_w_hs) begin
        r_w_data <= W_DATA;
        r_w_strb <= W_STRB;
      end
    end
  end

  assign w_rd_pend  = r_ar_full;
  assign w_wr_pend  = r_aw_full & r_w_full;
  assign w_pick_rd  = w_rd_pend & (~w_wr_pend | r_last_wr);
  assign w_sel_addr = w_pick_rd ? r_ar_addr : r_aw_addr;
  // Offset wraps to a huge value below BASE_ADDR, so one compare covers both window edges.
  assign w_oob      = (w_sel_addr - BASE_ADDR) >= ADDR_RANGE;
  assign w_mis      = (w_sel_addr & ALIGN_MASK) != '0;
  assign w_dec_resp = w_oob ? DECERR : SLVERR;
  assign w_tmo      = (TIMEOUT_CYCLES != 0) && (r_tcnt == 32'(TIMEOUT_CYCLES-1));
  assign w_mem_resp = (mem_ack_i && !mem_err_i) ? OKAY : SLVERR;
  assign w_mem_data = mem_ack_i ? mem_rdata_i : '0;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state     <= S_IDLE;
      r_last_wr   <= 1'b1;
      r_tcnt      <= '0;
      r_rvalid    <= 1'b0; r_rdata <= '0; r_rresp <= OKAY;
      r_bvalid    <= 1'b0; r_bresp <= OKAY;
      r_mem_req   <= 1'b0; r_mem_we <= 1'b0; r_mem_addr <= '0;
      r_mem_wdata <= '0;   r_mem_wstrb <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_rd_pend | w_wr_pend) begin
          r_last_wr <= ~w_pick_rd;
          if (w_oob | w_mis) begin
            if (w_pick_rd) begin
              r_rdata <= '0; r_rresp <= w_dec_resp; r_rvalid <= 1'b1; r_state <= S_RESP_R;
            end else begin
              r_bresp <= w_dec_resp; r_bvalid <= 1'b1; r_state <= S_RESP_W;
            end
          end else begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= ~w_pick_rd;
            r_mem_addr  <= w_sel_addr & ~ALIGN_MASK;
            r_mem_wdata <= w_pick_rd ? '0 : r_w_data;
            r_mem_wstrb <= w_pick_rd ? '0 : r_w_strb;
            r_tcnt      <= '0;
            r_state     <= w_pick_rd ? S_MEM_RD : S_MEM_WR;
          end
        end
        S_MEM_RD, S_MEM_WR: begin
          if (mem_ack_i || w_tmo) begin
            r_mem_req <= 1'b0;
            if (r_state == S_MEM_RD) begin
              r_rdata <= w_mem_data; r_rresp <= w_mem_resp; r_rvalid <= 1'b1; r_state <= S_RESP_R;
            end else begin
              r_bresp <= w_mem_resp; r_bvalid <= 1'b1; r_state <= S_RESP_W;
            end
          end else begin
            r_tcnt <= r_tcnt + 32'd1;
          end
        end
        S_RESP_R: if (R_READY) begin
          r_rvalid <= 1'b0; r_state <= S_IDLE;
        end
        S_RESP_W: if (B_READY) begin
          r_bvalid <= 1'b0; r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign AR_READY    = r_ar_rdy;
  assign AW_READY    = r_aw_rdy;
  assign W_READY     = r_w_rdy;
  assign R_VALID     = r_rvalid;
  assign R_DATA      = r_rdata;
  assign R_RESP      = r_rresp;
  assign B_VALID     = r_bvalid;
  assign B_RESP      = r_bresp;
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign mem_wstrb_o = r_mem_wstrb;
endmodule
